vgg16_dma_sequencer: RTL

//  Command-side initiator for the VGG16 feature-BRAM DMA engine. Queues transfer

---
 rtl/vgg16_dma_defs.sv | 18 +
 rtl/vgg16_dma_cmd_fifo.sv | 41 ++++
 rtl/vgg16_dma_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vgg16_dma_defs.sv
// rtl/vgg16_dma_defs.sv - shared definitions for the VGG16 feature-BRAM DMA sequencer
package vgg16_dma_defs;

  localparam int ADDR_W_DEF = 20;
  localparam int NUM_W_DEF  = 32;
  localparam int TO_W       = 24;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_HALT  = 4'b1000
  } state_e;

endpackage

// File: rtl/vgg16_dma_cmd_fifo.sv
// rtl/vgg16_dma_cmd_fifo.sv - show-ahead descriptor FIFO with full/empty flags
module vgg16_dma_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 53
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/vgg16_dma_sequencer.sv
// rtl/vgg16_dma_sequencer.sv - queues DMA descriptors and issues them one at a time to the engine
module vgg16_dma_sequencer
  import vgg16_dma_defs::*;
#(
  parameter int              FIFO_DEPTH     = 4,
  parameter int              ADDR_W         = ADDR_W_DEF,
  parameter int              NUM_W          = NUM_W_DEF,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  input  logic [NUM_W-1:0]  cmd_num,
  output logic              loaddma_start,
  output logic              storedma_start,
  output logic [ADDR_W-1:0] base_addr,
  output logic [NUM_W-1:0]  num,
  input  logic              loaddma_finish,
  input  logic              storedma_finish,
  output logic              dma_active,
  output logic              done,
  output logic [15:0]       done_cnt,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int FW = 1 + ADDR_W + NUM_W;

  state_e            state_q;
  logic              dir_q;
  logic [ADDR_W-1:0] base_addr_q;
  logic [NUM_W-1:0]  num_q;
  logic              load_start_q;
  logic              store_start_q;
  logic              dma_active_q;
  logic              done_q;
  logic [15:0]       done_cnt_q;
  logic              err_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [FW-1:0]     fifo_head;
  logic              head_dir;
  logic [ADDR_W-1:0] head_addr;
  logic [NUM_W-1:0]  head_num;
  logic              finish_sel;

  assign cmd_ready = !fifo_full && !rst;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  assign {head_dir, head_addr, head_num} = fifo_head;

  // Only the flag matching the in-flight direction is meaningful; the other may be X.
  assign finish_sel = (dir_q == DIR_STORE) ? storedma_finish : loaddma_finish;

  vgg16_dma_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i ({cmd_dir, cmd_base_addr, cmd_num}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_LOAD;
      base_addr_q   <= '0;
      num_q         <= '0;
      load_start_q  <= 1'b0;
      store_start_q <= 1'b0;
      dma_active_q  <= 1'b0;
      done_q        <= 1'b0;
      done_cnt_q    <= '0;
      err_q         <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      load_start_q  <= 1'b0;
      store_start_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            // Zero-length descriptors never reach the engine.
            if (head_num == '0) begin
              done_q     <= 1'b1;
              done_cnt_q <= done_cnt_q + 16'd1;
            end else begin
              dir_q         <= head_dir;
              base_addr_q   <= head_addr;
              num_q         <= head_num;
              load_start_q  <= (head_dir == DIR_LOAD);
              store_start_q <= (head_dir == DIR_STORE);
              dma_active_q  <= 1'b1;
              state_q       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          to_cnt_q <= {{(TO_W-1){1'b0}}, 1'b1};
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (finish_sel) begin
            done_q       <= 1'b1;
            done_cnt_q   <= done_cnt_q + 16'd1;
            dma_active_q <= 1'b0;
            state_q      <= ST_IDLE;
          end else if ((TIMEOUT_CYCLES != '0) && (to_cnt_q == TIMEOUT_CYCLES)) begin
            err_q        <= 1'b1;
            dma_active_q <= 1'b0;
            state_q      <= ST_HALT;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_HALT: begin
          if (err_clr) begin
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign loaddma_start  = load_start_q;
  assign storedma_start = store_start_q;
  assign base_addr      = base_addr_q;
  assign num            = num_q;
  assign dma_active     = dma_active_q;
  assign done           = done_q;
  assign done_cnt       = done_cnt_q;
  assign err_timeout    = err_q;

endmodule
